oram_frontend_arbiter: RTL and testbench

Two-requester front-end arbiter that shares a single TinyORAMCore command/data interface. It serializes whole ORAM transactions, holding one requester's grant across command issue plus either the write-data burst or the read-data burst. It alternates grants round-robin when both requesters contend. It sits between the client ports (for example, LLC-side and DMA-side) and TinyORAMCore's Cmd/PAddr/DataIn/DataOut handshakes.

---
 rtl/oram_frontend_arbiter.sv | 147 ++++++++++++++
 tb/tb_oram_frontend_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oram_frontend_arbiter.sv
// Two-requester front end for TinyORAMCore: one requester owns the ORAM from
// command accept through the last write or read beat; contention alternates.
module oram_frontend_arbiter #(
  parameter int ORAMB    = 512,
  parameter int ORAMU    = 32,
  parameter int FEDWidth = 64
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [1:0]          Cmd0,
  input  logic [ORAMU-1:0]    PAddr0,
  input  logic                CmdValid0,
  output logic                CmdReady0,
  input  logic [FEDWidth-1:0] DataIn0,
  input  logic                DataInValid0,
  output logic                DataInReady0,
  output logic [FEDWidth-1:0] DataOut0,
  output logic                DataOutValid0,
  input  logic                DataOutReady0,
  input  logic [1:0]          Cmd1,
  input  logic [ORAMU-1:0]    PAddr1,
  input  logic                CmdValid1,
  output logic                CmdReady1,
  input  logic [FEDWidth-1:0] DataIn1,
  input  logic                DataInValid1,
  output logic                DataInReady1,
  output logic [FEDWidth-1:0] DataOut1,
  output logic                DataOutValid1,
  input  logic                DataOutReady1,
  output logic [1:0]          Cmd,
  output logic [ORAMU-1:0]    PAddr,
  output logic                CmdValid,
  input  logic                CmdReady,
  output logic [FEDWidth-1:0] DataIn,
  output logic                DataInValid,
  input  logic                DataInReady,
  input  logic [FEDWidth-1:0] DataOut,
  input  logic                DataOutValid,
  output logic                DataOutReady,
  output logic [1:0]          Grant
);
  localparam int Chunks = ORAMB / FEDWidth;
  localparam int CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(Chunks - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WDATA, RDATA} state_t;

  state_t           state, stateNext;
  logic [1:0]       grant, grantNext;
  logic             lastGrant, lastGrantNext; // 1: requester 1 owned the last transaction
  logic [1:0]       cmdQ, cmdNext;
  logic [ORAMU-1:0] pAddrQ, pAddrNext;
  logic [CntW-1:0]  cnt, cntNext;
  logic             win0, win1, sel1;

  assign sel1  = grant[1];
  assign Grant = grant;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      lastGrant <= 1'b1;
      cmdQ      <= '0;
      pAddrQ    <= '0;
      cnt       <= '0;
    end else begin
      state     <= stateNext;
      grant     <= grantNext;
      lastGrant <= lastGrantNext;
      cmdQ      <= cmdNext;
      pAddrQ    <= pAddrNext;
      cnt       <= cntNext;
    end
  end

  always_comb begin
    stateNext     = state;
    grantNext     = grant;
    lastGrantNext = lastGrant;
    cmdNext       = cmdQ;
    pAddrNext     = pAddrQ;
    cntNext       = cnt;
    win0          = CmdValid0 & (~CmdValid1 | lastGrant);
    win1          = CmdValid1 & (~CmdValid0 | ~lastGrant);
    CmdReady0     = 1'b0;
    CmdReady1     = 1'b0;
    Cmd           = cmdQ;
    PAddr         = pAddrQ;
    CmdValid      = 1'b0;
    DataIn        = sel1 ? DataIn1 : DataIn0;
    DataInValid   = 1'b0;
    DataInReady0  = 1'b0;
    DataInReady1  = 1'b0;
    DataOut0      = DataOut;
    DataOut1      = DataOut;
    DataOutValid0 = 1'b0;
    DataOutValid1 = 1'b0;
    DataOutReady  = 1'b0;
    case (state)
      IDLE: begin
        // reset gating keeps the accept strobes low while Reset_n is held
        CmdReady0 = win0 & Reset_n;
        CmdReady1 = win1 & Reset_n;
        if (win0 | win1) begin
          stateNext     = ISSUE;
          grantNext     = {win1, win0};
          lastGrantNext = win1;
          cmdNext       = win1 ? Cmd1 : Cmd0;
          pAddrNext     = win1 ? PAddr1 : PAddr0;
        end
      end
      ISSUE: begin
        CmdValid = 1'b1;
        if (CmdReady) begin
          stateNext = cmdQ[1] ? RDATA : WDATA;
          cntNext   = '0;
        end
      end
      WDATA: begin
        DataInValid  = sel1 ? DataInValid1 : DataInValid0;
        DataInReady0 = grant[0] & DataInReady;
        DataInReady1 = grant[1] & DataInReady;
        if (DataInValid & DataInReady) begin
          cntNext = cnt + 1'b1;
          if (cnt == LastBeat) begin
            stateNext = IDLE;
            grantNext = '0;
          end
        end
      end
      RDATA: begin
        DataOutValid0 = grant[0] & DataOutValid;
        DataOutValid1 = grant[1] & DataOutValid;
        DataOutReady  = sel1 ? DataOutReady1 : DataOutReady0;
        if (DataOutValid & DataOutReady) begin
          cntNext = cnt + 1'b1;
          if (cnt == LastBeat) begin
            stateNext = IDLE;
            grantNext = '0;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_oram_frontend_arbiter.sv
// Bench for oram_frontend_arbiter: IDLE arbitration table, directed corner
// sequences, then randomized traffic against a transaction-level model.
module tb_oram_frontend_arbiter;
  localparam int ORAMB = 512, ORAMU = 32, FEDW = 64, CH = ORAMB / FEDW, NTX = 6;

  logic Clock = 1'b0, Reset_n = 1'b1;
  logic [1:0]       cvV, divV, dorV;
  logic [1:0]       cmdV  [2];
  logic [ORAMU-1:0] addrV [2];
  logic [FEDW-1:0]  dinV  [2];
  logic CmdReady0, CmdReady1, DataInReady0, DataInReady1, DataOutValid0, DataOutValid1;
  logic [FEDW-1:0] DataOut0, DataOut1, DataIn, oDout;
  logic [1:0] Cmd, Grant;
  logic [ORAMU-1:0] PAddr;
  logic CmdValid, DataInValid, DataOutReady, oCmdReady, oDinReady, oDov;

  oram_frontend_arbiter #(.ORAMB(ORAMB), .ORAMU(ORAMU), .FEDWidth(FEDW)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Cmd0(cmdV[0]), .PAddr0(addrV[0]), .CmdValid0(cvV[0]), .CmdReady0(CmdReady0),
    .DataIn0(dinV[0]), .DataInValid0(divV[0]), .DataInReady0(DataInReady0),
    .DataOut0(DataOut0), .DataOutValid0(DataOutValid0), .DataOutReady0(dorV[0]),
    .Cmd1(cmdV[1]), .PAddr1(addrV[1]), .CmdValid1(cvV[1]), .CmdReady1(CmdReady1),
    .DataIn1(dinV[1]), .DataInValid1(divV[1]), .DataInReady1(DataInReady1),
    .DataOut1(DataOut1), .DataOutValid1(DataOutValid1), .DataOutReady1(dorV[1]),
    .Cmd(Cmd), .PAddr(PAddr), .CmdValid(CmdValid), .CmdReady(oCmdReady),
    .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(oDinReady),
    .DataOut(oDout), .DataOutValid(oDov), .DataOutReady(DataOutReady),
    .Grant(Grant)
  );

  always #5 Clock = ~Clock;

  int nChk = 0, nPass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else nPass++;
  endtask

  task automatic cyc();
    @(posedge Clock); #1;
  endtask

  task automatic clearIn();
    cvV = '0; divV = '0; dorV = '0;
    for (int r = 0; r < 2; r++) begin
      cmdV[r] = '0; addrV[r] = '0; dinV[r] = '0;
    end
    oCmdReady = 1'b0; oDinReady = 1'b0; oDov = 1'b0; oDout = '0;
  endtask

  task automatic doReset();
    clearIn();
    Reset_n = 1'b0;
    cyc();
    Reset_n = 1'b1;
  endtask

  // ---------------- transaction-level reference model ----------------
  int busy, owner, issued, isWr, beats, lastW, txIdx;
  int accCnt [2];
  logic [1:0]       pCmd;
  logic [ORAMU-1:0] pAddr;
  logic [63:0]      expRd, oNext;
  int ph [2], dly [2], rTx [2], rBeat [2];
  logic [1:0] cmdHs, dinHs, doutHs;
  logic oDoutHs;

  function automatic logic [63:0] mkData(input int r, input int t, input int b);
    return {16'hA000 | 16'(r), 16'(t), 32'(b)};
  endfunction

  task automatic monitor();
    logic e0, e1;
    logic [1:0] rdy, dir, dov;
    rdy = {CmdReady1, CmdReady0};
    dir = {DataInReady1, DataInReady0};
    dov = {DataOutValid1, DataOutValid0};
    cmdHs = cvV & rdy; dinHs = divV & dir; doutHs = dov & dorV;
    oDoutHs = oDov & DataOutReady;
    if (busy == 0) begin
      e0 = cvV[0] && (!cvV[1] || lastW == 1);
      e1 = cvV[1] && (!cvV[0] || lastW == 0);
      chk("r_arb_rdy", 64'(rdy), 64'({e1, e0}));
      chk("r_idle_grant", 64'(Grant), 64'd0);
      chk("r_idle_outs", 64'({CmdValid, DataInValid, DataOutReady, dir, dov}), 64'd0);
      if (e0 || e1) begin
        owner = e1 ? 1 : 0; lastW = owner; busy = 1; issued = 0;
        pCmd = cmdV[owner]; pAddr = addrV[owner];
        txIdx = accCnt[owner]; accCnt[owner]++;
      end
    end else begin
      chk("r_grant", 64'(Grant), (owner == 1) ? 64'd2 : 64'd1);
      chk("r_rdy_busy", 64'(rdy), 64'd0);
      if (issued == 0) begin
        chk("r_cmdvalid", 64'(CmdValid), 64'd1);
        chk("r_cmd", 64'(Cmd), 64'(pCmd));
        chk("r_paddr", 64'(PAddr), 64'(pAddr));
        chk("r_issue_outs", 64'({DataInValid, DataOutReady, dir, dov}), 64'd0);
        if (oCmdReady) begin issued = 1; isWr = (pCmd < 2'd2) ? 1 : 0; beats = 0; end
      end else if (isWr != 0) begin
        chk("r_w_cmdvalid", 64'(CmdValid), 64'd0);
        chk("r_w_div", 64'(DataInValid), 64'(divV[owner]));
        chk("r_w_dir", 64'(dir), oDinReady ? (64'd1 << owner) : 64'd0);
        chk("r_w_rdside", 64'({DataOutReady, dov}), 64'd0);
        if (DataInValid && oDinReady) begin
          chk("r_wdata", DataIn, mkData(owner, txIdx, beats));
          beats++;
          if (beats == CH) busy = 0;
        end
      end else begin
        chk("r_r_cmdvalid", 64'(CmdValid), 64'd0);
        chk("r_r_dov", 64'(dov), oDov ? (64'd1 << owner) : 64'd0);
        chk("r_r_dor", 64'(DataOutReady), 64'(dorV[owner]));
        chk("r_r_wrside", 64'({DataInValid, dir}), 64'd0);
        if (oDov && DataOutReady) begin
          chk("r_rdata", (owner == 1) ? DataOut1 : DataOut0, expRd);
          expRd++;
          beats++;
          if (beats == CH) busy = 0;
        end
      end
    end
  endtask

  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      case (ph[r])
        0: if (rTx[r] < NTX) begin
             if (dly[r] == 0) begin
               ph[r] = 1; cvV[r] = 1'b1;
               cmdV[r] = 2'($urandom % 4); addrV[r] = $urandom;
             end else dly[r]--;
           end
        1: if (cmdHs[r]) begin
             cvV[r] = 1'b0; rBeat[r] = 0;
             ph[r] = (cmdV[r] < 2'd2) ? 2 : 3;
           end
        default: if ((ph[r] == 2 && dinHs[r]) || (ph[r] == 3 && doutHs[r])) begin
             rBeat[r]++;
             if (rBeat[r] == CH) begin ph[r] = 0; rTx[r]++; dly[r] = int'($urandom % 4); end
           end
      endcase
      // idle requesters also wiggle data valid/ready to prove they are ignored
      divV[r] = (ph[r] == 2) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      dinV[r] = (ph[r] == 2) ? mkData(r, rTx[r], rBeat[r]) : 64'hBAD0 + 64'(r);
      dorV[r] = (ph[r] == 3) ? (($urandom % 3) != 0) : 1'($urandom % 2);
    end
    if (oDoutHs) oNext++;
    oDout = oNext;
    oDov = 1'($urandom % 2);
    oCmdReady = ($urandom % 3) == 0;
    oDinReady = 1'($urandom % 2);
  endtask

  typedef struct {
    logic rstn, cv0, cv1, e0, e1;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int k;
    bit done;
    clearIn();
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_grant", 64'(Grant), 64'd0);
    chk("rst_outs", 64'({CmdValid, DataInValid, DataOutReady, CmdReady0, CmdReady1,
                         DataInReady0, DataInReady1, DataOutValid0, DataOutValid1}), 64'd0);
    cyc();
    Reset_n = 1'b1;

    // IDLE arbitration after reset: LastGrant=req1, so req0 wins contention
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      Reset_n = tbl[i].rstn;
      cvV = {tbl[i].cv1, tbl[i].cv0};
      #1;
      chk($sformatf("tbl%0d_rdy0", i), 64'(CmdReady0), 64'(tbl[i].e0));
      chk($sformatf("tbl%0d_rdy1", i), 64'(CmdReady1), 64'(tbl[i].e1));
      chk($sformatf("tbl%0d_cv", i), 64'({Grant, CmdValid}), 64'd0);
      cvV = '0;
      Reset_n = 1'b1;
    end

    // Update from req0 at 0x5, req1 pushing stray write beats throughout
    cyc();
    cmdV[0] = 2'd0; addrV[0] = 5; cvV[0] = 1'b1;
    divV[1] = 1'b1; dinV[1] = 64'hDEAD;
    #1;
    chk("A_rdy0", 64'(CmdReady0), 64'd1);
    chk("A_cv_pre", 64'(CmdValid), 64'd0);
    cyc();
    cvV[0] = 1'b0;
    #1;
    chk("A_cmdvalid", 64'(CmdValid), 64'd1);
    chk("A_cmd", 64'(Cmd), 64'd0);
    chk("A_paddr", 64'(PAddr), 64'd5);
    chk("A_grant", 64'(Grant), 64'd1);
    oCmdReady = 1'b1;
    cyc();
    oCmdReady = 1'b0; oDinReady = 1'b1; divV[0] = 1'b1;
    for (int b = 0; b < CH; b++) begin
      dinV[0] = 64'(5 + b);
      #1;
      chk("A_din", DataIn, 64'(5 + b));
      chk("A_dinvalid", 64'(DataInValid), 64'd1);
      chk("A_dir", 64'({DataInReady1, DataInReady0}), 64'd1);
      cyc();
    end
    divV = '0; oDinReady = 1'b0;
    #1;
    chk("A_grant_idle", 64'(Grant), 64'd0);
    chk("A_div_idle", 64'(DataInValid), 64'd0);

    // Read from req1 at 0x3: ISSUE stalled 20 cycles, then toggling ready
    cmdV[1] = 2'd2; addrV[1] = 3; cvV[1] = 1'b1;
    #1;
    chk("C_rdy1", 64'(CmdReady1), 64'd1);
    cyc();
    cvV[1] = 1'b0;
    cvV[0] = 1'b1; cmdV[0] = 2'd2; addrV[0] = 9;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("C_stall_cv", 64'(CmdValid), 64'd1);
      chk("C_stall_cmd", 64'({Cmd, PAddr}), 64'({2'd2, 32'd3}));
      chk("C_stall_rdy", 64'({CmdReady1, CmdReady0}), 64'd0);
      cyc();
    end
    oCmdReady = 1'b1;
    cyc();
    oCmdReady = 1'b0; oDov = 1'b1; dorV[0] = 1'b1;
    k = 0;
    for (int i = 0; i < 2 * CH; i++) begin
      dorV[1] = (i % 2) == 1;
      oDout = 64'(64'h30 + k);
      #1;
      chk("C_dov", 64'({DataOutValid1, DataOutValid0}), 64'd2);
      chk("C_dor", 64'(DataOutReady), 64'((i % 2) == 1));
      if ((i % 2) == 1) begin
        chk("C_rdata", DataOut1, 64'(64'h30 + k));
        k++;
      end
      cyc();
    end
    oDov = 1'b0; dorV = '0;
    #1;
    chk("C_grant_idle", 64'(Grant), 64'd0);
    cmdV[0] = 2'd1; addrV[0] = 7;
    #1;
    chk("C_rdy0_waiter", 64'(CmdReady0), 64'd1);

    // Append from req0, reset after beat 3
    cyc();
    cvV[0] = 1'b0; oCmdReady = 1'b1;
    cyc();
    oCmdReady = 1'b0; oDinReady = 1'b1; divV[0] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      dinV[0] = 64'(b);
      #1;
      chk("B_dir0", 64'(DataInReady0), 64'd1);
      cyc();
    end
    cvV = 2'b11; divV = 2'b11; dorV = 2'b11; oDov = 1'b1; oCmdReady = 1'b1;
    Reset_n = 1'b0;
    #1;
    chk("B_rst_outs", 64'({CmdValid, DataInValid, DataOutReady, CmdReady0, CmdReady1,
                           DataInReady0, DataInReady1, DataOutValid0, DataOutValid1}), 64'd0);
    chk("B_rst_grant", 64'(Grant), 64'd0);
    cyc();
    Reset_n = 1'b1;
    divV = '0; dorV = '0; oDov = 1'b0; oCmdReady = 1'b0; oDinReady = 1'b0;
    #1;
    chk("B_after_rdy", 64'({CmdReady1, CmdReady0}), 64'd1);
    cvV = '0;

    // Randomized traffic
    doReset();
    busy = 0; lastW = 1; expRd = 64'h100; oNext = 64'h100; oDout = oNext;
    for (int r = 0; r < 2; r++) begin
      accCnt[r] = 0; ph[r] = 0; rTx[r] = 0; rBeat[r] = 0; dly[r] = r;
    end
    done = 0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge Clock);
      monitor();
      if (rTx[0] == NTX && rTx[1] == NTX && busy == 0) begin done = 1; break; end
      @(posedge Clock); #1;
      drive();
    end
    chk("r_done", 64'(done), 64'd1);
    chk("r_acc0", 64'(accCnt[0]), 64'(NTX));
    chk("r_acc1", 64'(accCnt[1]), 64'(NTX));

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
